// File: rtl/stencil_window_server_if.sv
`default_nettype none
// ============================================================================
//  Module      : stencil_window_server_if
//  Description : Pixel stream push, 3x3 window read request/response and
//                status signals between a stencil consumer and the window
//                server.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stencil_window_server_if #(
   parameter int DATA_W = 32
);
   logic                  in_valid;
   logic [DATA_W-1:0]     in_data;
   logic                  rd_en;
   logic [9*DATA_W-1:0]   rd_data;
   logic                  rd_valid;
   logic                  rd_miss;
   logic                  win_valid;
   logic                  frame_done;

   // Pixel source and stencil consumer side
   modport master (
      output in_valid, in_data, rd_en,
      input  rd_data, rd_valid, rd_miss, win_valid, frame_done
   );

   // Window server side
   modport slave (
      input  in_valid, in_data, rd_en,
      output rd_data, rd_valid, rd_miss, win_valid, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/stencil_window_server.sv
`default_nettype none
// ============================================================================
//  Module      : stencil_window_server
//  Description : Buffers two image lines plus a 3x3 register window from a
//                raster pixel stream and returns the full neighbourhood one
//                cycle after a read request.
//  Revision    : 1.0 - initial release
// ============================================================================
module stencil_window_server #(
   parameter int DATA_W = 32,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  wire logic               clk,
   input  wire logic               rstn,
   stencil_window_server_if.slave  sw_io
);
   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] C_ROW_LAST = ROW_W'(IMG_H - 1);
   localparam logic [COL_W-1:0] C_COL_TWO  = COL_W'(2);
   localparam logic [ROW_W-1:0] C_ROW_TWO  = ROW_W'(2);

   // Raster position of the next pixel to be pushed
   logic [COL_W-1:0]      col_q, col_d;
   logic [ROW_W-1:0]      row_q, row_d;
   // Window element k = 3*row + column, row 0 oldest, column 0 oldest
   logic [DATA_W-1:0]     win_q [9];
   logic [DATA_W-1:0]     win_d [9];
   logic                  win_valid_q, win_valid_d;
   logic                  frame_done_q, frame_done_d;
   logic [9*DATA_W-1:0]   rd_data_q, rd_data_d;
   logic                  rd_valid_q, rd_valid_d;
   logic                  rd_miss_q, rd_miss_d;
   // lb0 holds the previous line, lb1 the line before that
   logic [DATA_W-1:0]     lb0_q [IMG_W];
   logic [DATA_W-1:0]     lb1_q [IMG_W];
   logic [9*DATA_W-1:0]   win_flat;

   for (genvar k = 0; k < 9; k++) begin : g_pack
      assign win_flat[k*DATA_W +: DATA_W] = win_q[k];
   end

   // Next-state: window shift, raster counters and read response
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      win_d        = win_q;
      win_valid_d  = win_valid_q;
      frame_done_d = 1'b0;
      if (sw_io.in_valid) begin
         for (int i = 0; i < 3; i++) begin
            win_d[3*i]     = win_q[3*i+1];
            win_d[3*i + 1] = win_q[3*i+2];
         end
         win_d[2] = lb1_q[col_q];
         win_d[5] = lb0_q[col_q];
         win_d[8] = sw_io.in_data;
         // Requiring col>=2 keeps a window from straddling a line boundary
         win_valid_d = (row_q >= C_ROW_TWO) && (col_q >= C_COL_TWO);
         if (col_q == C_COL_LAST) begin
            col_d = '0;
            if (row_q == C_ROW_LAST) begin
               row_d        = '0;
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + ROW_W'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
      // Reads see the pre-edge window, so a simultaneous push does not leak in
      rd_valid_d = sw_io.rd_en & win_valid_q;
      rd_miss_d  = sw_io.rd_en & ~win_valid_q;
      rd_data_d  = rd_valid_d ? win_flat : rd_data_q;
   end

   // Control, window and response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         col_q        <= '0;
         row_q        <= '0;
         for (int k = 0; k < 9; k++) begin
            win_q[k] <= '0;
         end
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         rd_miss_q    <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         win_q        <= win_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         rd_miss_q    <= rd_miss_d;
      end
   end

   // Line buffers are not reset; rows 0-1 of each frame mask stale contents
   always_ff @(posedge clk) begin
      if (sw_io.in_valid) begin
         lb1_q[col_q] <= lb0_q[col_q];
         lb0_q[col_q] <= sw_io.in_data;
      end
   end

   assign sw_io.rd_data    = rd_data_q;
   assign sw_io.rd_valid   = rd_valid_q;
   assign sw_io.rd_miss    = rd_miss_q;
   assign sw_io.win_valid  = win_valid_q;
   assign sw_io.frame_done = frame_done_q;
endmodule
`default_nettype wire

// File: tb/tb_stencil_window_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stencil_window_server
//  Description : Directed scoreboard bench for stencil_window_server on a
//                4x4 image.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stencil_window_server;
   localparam int DATA_W = 32;
   localparam int WW     = 9*DATA_W;
   localparam logic [1:0] K_READ  = 2'd0;
   localparam logic [1:0] K_MISS  = 2'd1;
   localparam logic [1:0] K_FRAME = 2'd2;

   typedef struct packed {
      logic [1:0]    kind;
      logic [WW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   tests = 0;
   int   fails = 0;
   exp_t exp_q[$];
   logic [WW-1:0] last_rd;

   stencil_window_server_if #(.DATA_W(DATA_W)) bus ();

   stencil_window_server #(
      .DATA_W(DATA_W),
      .IMG_W (4),
      .IMG_H (4)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .sw_io(bus)
   );

   always #5 clk = ~clk;

   function automatic logic [WW-1:0] mkwin(input int a, input int b, input int c,
                                           input int d, input int e, input int f,
                                           input int g, input int h, input int i);
      logic [WW-1:0] w;
      w = {DATA_W'(i), DATA_W'(h), DATA_W'(g), DATA_W'(f), DATA_W'(e),
           DATA_W'(d), DATA_W'(c), DATA_W'(b), DATA_W'(a)};
      return w;
   endfunction

   task automatic exp_read(input logic [WW-1:0] w);
      exp_t e;
      e.kind = K_READ;
      e.data = w;
      exp_q.push_back(e);
      last_rd = w;
   endtask

   task automatic exp_miss();
      exp_t e;
      e.kind = K_MISS;
      e.data = last_rd;
      exp_q.push_back(e);
   endtask

   task automatic exp_frame();
      exp_t e;
      e.kind = K_FRAME;
      e.data = '0;
      exp_q.push_back(e);
   endtask

   // One clock of stimulus; inputs change 1 time unit after the rising edge
   task automatic drive(input logic iv, input int v, input logic re);
      bus.in_valid = iv;
      bus.in_data  = DATA_W'(v);
      bus.rd_en    = re;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.rd_en    = 1'b0;
   endtask

   task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      drive(1'b0, 0, 1'b0);
      drive(1'b0, 0, 1'b0);
      rstn = 1'b1;
      last_rd = '0;
   endtask

   task automatic check_evt(input logic [1:0] k);
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event kind got=%0d with nothing expected", k);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || (k != K_FRAME && bus.rd_data !== e.data)) begin
            fails++;
            $display("FAIL event kind got=%0d exp=%0d rd_data got=%h exp=%h",
                     k, e.kind, bus.rd_data, e.data);
         end
      end
   endtask

   // Monitor: every response pulse is matched against the scoreboard queue
   always @(negedge clk) begin
      if (bus.rd_valid === 1'b1)   check_evt(K_READ);
      if (bus.rd_miss === 1'b1)    check_evt(K_MISS);
      if (bus.frame_done === 1'b1) check_evt(K_FRAME);
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rstn         = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.rd_en    = 1'b0;
      last_rd      = '0;
      do_reset();

      chk("rst_rd_data",    bus.rd_data,           '0);
      chk("rst_rd_valid",   WW'(bus.rd_valid),     '0);
      chk("rst_rd_miss",    WW'(bus.rd_miss),      '0);
      chk("rst_win_valid",  WW'(bus.win_valid),    '0);
      chk("rst_frame_done", WW'(bus.frame_done),   '0);

      // Read with no pixels yet
      exp_miss();
      drive(1'b0, 0, 1'b1);
      chk("miss_rd_data_zero", bus.rd_data, '0);

      // Frame 1: pixels 0..9 give no window
      for (int p = 0; p < 10; p++) begin
         drive(1'b1, p, 1'b0);
         chk($sformatf("f1_wv_p%0d", p), WW'(bus.win_valid), '0);
      end
      drive(1'b1, 10, 1'b0);
      chk("f1_wv_p10", WW'(bus.win_valid), WW'(1));
      exp_read(mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10));
      drive(1'b0, 0, 1'b1);

      // Read together with push of 11 returns the pixel-10 window
      exp_read(mkwin(0, 1, 2, 4, 5, 6, 8, 9, 10));
      drive(1'b1, 11, 1'b1);
      chk("f1_wv_p11", WW'(bus.win_valid), WW'(1));

      // Back-to-back reads
      exp_read(mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11));
      drive(1'b0, 0, 1'b1);
      exp_read(mkwin(1, 2, 3, 5, 6, 7, 9, 10, 11));
      drive(1'b0, 0, 1'b1);

      // Line start: no window, read misses and rd_data holds
      drive(1'b1, 12, 1'b0);
      chk("f1_wv_p12", WW'(bus.win_valid), '0);
      exp_miss();
      drive(1'b0, 0, 1'b1);
      drive(1'b1, 13, 1'b0);
      chk("f1_wv_p13", WW'(bus.win_valid), '0);
      drive(1'b1, 14, 1'b0);
      chk("f1_wv_p14", WW'(bus.win_valid), WW'(1));
      exp_read(mkwin(4, 5, 6, 8, 9, 10, 12, 13, 14));
      drive(1'b0, 0, 1'b1);

      // Last pixel: window valid and frame_done pulse
      exp_frame();
      drive(1'b1, 15, 1'b0);
      chk("f1_wv_p15", WW'(bus.win_valid), WW'(1));
      exp_read(mkwin(5, 6, 7, 9, 10, 11, 13, 14, 15));
      drive(1'b0, 0, 1'b1);

      // Frame 2: values +100, no frame-1 data visible
      for (int p = 0; p < 10; p++) begin
         drive(1'b1, 100 + p, 1'b0);
         chk($sformatf("f2_wv_p%0d", p), WW'(bus.win_valid), '0);
      end
      drive(1'b1, 110, 1'b0);
      chk("f2_wv_p10", WW'(bus.win_valid), WW'(1));
      exp_read(mkwin(100, 101, 102, 104, 105, 106, 108, 109, 110));
      drive(1'b0, 0, 1'b1);
      drive(1'b1, 111, 1'b0);

      // Reset mid-frame
      do_reset();
      chk("rst2_rd_data",   bus.rd_data,        '0);
      chk("rst2_win_valid", WW'(bus.win_valid), '0);
      for (int p = 0; p < 10; p++) begin
         drive(1'b1, 200 + p, 1'b0);
         chk($sformatf("f3_wv_p%0d", p), WW'(bus.win_valid), '0);
      end

      // Reset after pixel 9, then a fresh frame
      do_reset();
      chk("rst3_win_valid", WW'(bus.win_valid), '0);
      for (int p = 0; p < 10; p++) begin
         drive(1'b1, 300 + p, 1'b0);
         chk($sformatf("f4_wv_p%0d", p), WW'(bus.win_valid), '0);
      end
      drive(1'b1, 310, 1'b0);
      chk("f4_wv_p10", WW'(bus.win_valid), WW'(1));
      exp_read(mkwin(300, 301, 302, 304, 305, 306, 308, 309, 310));
      drive(1'b0, 0, 1'b1);

      repeat (3) drive(1'b0, 0, 1'b0);
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
